// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and helpers for the register file / scoreboard.
//   DEF_DATA_W, DEF_ADDR_W, DEF_NUM_RD : default parameter values
//   sliceLo(idx, width)                : low bit of slice idx in a packed multi-port bus
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port
// One combinational read port: data mux plus busy lookup, with optional
// same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
// Ports:
//   rdAddr  in  : register index to read
//   regs    in  : full register array (packed, entry 0 is always zero)
//   busy    in  : full busy vector (bit 0 is always clear)
//   wrEn/wrAddr/wrData in : current write, present only with REGFILE_BYPASS_EN
//   rdData  out : selected register contents
//   rdBusy  out : busy flag of the selected register
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   rdAddr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
  input  logic [(2**ADDR_W)-1:0]              busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                                wrEn,
  input  logic [ADDR_W-1:0]                   wrAddr,
  input  logic [DATA_W-1:0]                   wrData,
`endif
  output logic [DATA_W-1:0]                   rdData,
  output logic                                rdBusy
);

  always_comb begin
    rdData = regs[rdAddr];
    rdBusy = busy[rdAddr];
`ifdef REGFILE_BYPASS_EN
    // A write landing on this register this cycle both supplies the data
    // and resolves the pending result, so the reader sees it as ready.
    if (wrEn && (wrAddr == rdAddr) && (rdAddr != '0)) begin
      rdData = wrData;
      rdBusy = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with combinational multi-port reads and a per-register busy
// (pending-result) scoreboard. Register 0 is hard zero and never busy.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   rd_addr/rd_data   : NUM_RD packed read ports (port i at slice i)
//   rd_busy           : busy flag of each read port's register
//   wr_en/wr_addr/wr_data : write port, clears busy of the target
//   rsv_en/rsv_addr   : reservation request, sets busy of the target
//   rsv_ok            : reservation accepted this cycle (combinational)
//   busy_cnt          : registered count of busy registers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busyNext;
  logic [ADDR_W:0]              busyCnt;
  logic                         wrHit;
  logic                         rsvHit;
  logic                         cntInc;
  logic                         cntDec;

  assign wrHit = wr_en && (wr_addr != '0);

  // A busy register may be re-reserved only when the write retiring it
  // arrives in the same cycle.
  assign rsv_ok = rsv_en && ((rsv_addr == '0) || !busy[rsv_addr] ||
                             (wr_en && (wr_addr == rsv_addr)));
  assign rsvHit = rsv_ok && (rsv_addr != '0);

  // Count only real transitions of busy[]: a reservation re-arming a
  // register that is being retired leaves the population unchanged.
  assign cntInc = rsvHit && !busy[rsv_addr];
  assign cntDec = wrHit && busy[wr_addr] && !(rsvHit && (rsv_addr == wr_addr));

  always_comb begin
    busyNext = busy;
    if (wrHit)  busyNext[wr_addr]  = 1'b0;
    if (rsvHit) busyNext[rsv_addr] = 1'b1;
  end

  // State update stage: register contents, busy vector, busy population.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs    <= '0;
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      if (wrHit) regs[wr_addr] <= wr_data;
      busy    <= busyNext;
      busyCnt <= busyCnt + {{ADDR_W{1'b0}}, cntInc} - {{ADDR_W{1'b0}}, cntDec};
    end
  end

  assign busy_cnt = busyCnt;

`ifdef REGFILE_BYPASS_EN
  // No forwarding while held in reset, so reads stay at zero.
  logic wrFwd;
  assign wrFwd = wr_en && rst_n;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) uRdPort (
      .rdAddr (rd_addr[sliceLo(i, ADDR_W) +: ADDR_W]),
      .regs   (regs),
      .busy   (busy),
`ifdef REGFILE_BYPASS_EN
      .wrEn   (wrFwd),
      .wrAddr (wr_addr),
      .wrData (wr_data),
`endif
      .rdData (rd_data[sliceLo(i, DATA_W) +: DATA_W]),
      .rdBusy (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
`timescale 1ns/1ps
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic [ADDR_W:0]          busy_cnt;

  int nChecks;
  int nPass;

  // Reference model: register contents, pending flags, busy population.
  logic [DATA_W-1:0] mRegs [DEPTH];
  bit                mBusy [DEPTH];
  int                mCnt;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit expRsvOk();
    return rsv_en && (rsv_addr == 0 || !mBusy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
  endfunction

  function automatic logic [DATA_W-1:0] expRd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_en && wr_addr == a && a != 0) return wr_data;
`endif
    return (a == 0) ? '0 : mRegs[a];
  endfunction

  function automatic bit expBusy(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_en && wr_addr == a && a != 0) return 1'b0;
`endif
    return mBusy[a];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < DEPTH; k++) begin
      mRegs[k] = '0;
      mBusy[k] = 1'b0;
    end
    mCnt = 0;
  endtask

  task automatic modelEdge();
    bit acc;
    acc = expRsvOk();
    if (wr_en && wr_addr != 0) begin
      mRegs[wr_addr] = wr_data;
      mBusy[wr_addr] = 1'b0;
    end
    if (acc && rsv_addr != 0) mBusy[rsv_addr] = 1'b1;
    mCnt = 0;
    for (int k = 0; k < DEPTH; k++) mCnt += int'(mBusy[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelEdge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rndAddr();
    if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  task automatic test_reset();
    #3;
    nChecks++; if (busy_cnt !== '0) $display("FAIL reset_init_cnt: got %0d want 0", busy_cnt); else nPass++;
    nChecks++; if (rd_data !== '0) $display("FAIL reset_init_rd: got %0h want 0", rd_data); else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(1, 31)); wr_data = $urandom;
      rsv_en = 1'b1; rsv_addr = ADDR_W'($urandom_range(1, 31));
      tick();
    end
    idle();
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    nChecks++; if (busy_cnt !== '0) $display("FAIL reset_async_cnt: got %0d want 0", busy_cnt); else nPass++;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1;
    nChecks++; if (rsv_ok !== 1'b1) $display("FAIL reset_rsv_ok: got %b want 1", rsv_ok); else nPass++;
    // Stay in reset across several edges while writes and reservations are offered.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = $urandom;
      rsv_addr = ADDR_W'(a);
      rd_addr[0 +: ADDR_W] = ADDR_W'(a);
      rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(DEPTH - 1 - a);
      #1;
      nChecks++; if (rd_data !== '0) $display("FAIL reset_rd a=%0d: got %0h want 0", a, rd_data); else nPass++;
      nChecks++; if (rd_busy !== '0) $display("FAIL reset_busy a=%0d: got %b want 00", a, rd_busy); else nPass++;
      #1;
    end
    nChecks++; if (busy_cnt !== '0) $display("FAIL reset_hold_cnt: got %0d want 0", busy_cnt); else nPass++;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000F0F0;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd3;
    #1;
    nChecks++; if (rd_data[0 +: DATA_W] !== 32'h0000F0F0) $display("FAIL wr_rd3: got %0h want 0000f0f0", rd_data[0 +: DATA_W]); else nPass++;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd0;
    #1;
    nChecks++; if (rd_data[0 +: DATA_W] !== 32'h0) $display("FAIL wr_rd0: got %0h want 0", rd_data[0 +: DATA_W]); else nPass++;
    nChecks++; if (busy_cnt !== '0) $display("FAIL wr_rd0_cnt: got %0d want 0", busy_cnt); else nPass++;
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd5;
    #1;
    nChecks++; if (rsv_ok !== 1'b1) $display("FAIL rsv5_ok: got %b want 1", rsv_ok); else nPass++;
    tick();
    rd_addr[0 +: ADDR_W] = 5'd5;
    #1;
    nChecks++; if (rd_busy[0] !== 1'b1) $display("FAIL rsv5_busy: got %b want 1", rd_busy[0]); else nPass++;
    nChecks++; if (busy_cnt !== 6'd1) $display("FAIL rsv5_cnt: got %0d want 1", busy_cnt); else nPass++;
    nChecks++; if (rsv_ok !== 1'b0) $display("FAIL rsv5_again: got %b want 0", rsv_ok); else nPass++;
    tick();
    nChecks++; if (busy_cnt !== 6'd1) $display("FAIL rsv5_reject_cnt: got %0d want 1", busy_cnt); else nPass++;
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    tick();
    idle();
    #1;
    nChecks++; if (rd_busy[0] !== 1'b0) $display("FAIL wr5_busy: got %b want 0", rd_busy[0]); else nPass++;
    nChecks++; if (busy_cnt !== 6'd0) $display("FAIL wr5_cnt: got %0d want 0", busy_cnt); else nPass++;
    nChecks++; if (rd_data[0 +: DATA_W] !== 32'h55) $display("FAIL wr5_data: got %0h want 55", rd_data[0 +: DATA_W]); else nPass++;
  endtask

  task automatic test_write_rsv_same();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    #1;
    nChecks++; if (rsv_ok !== 1'b1) $display("FAIL same7_ok: got %b want 1", rsv_ok); else nPass++;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd7;
    #1;
    nChecks++; if (rd_data[0 +: DATA_W] !== 32'hA5A5A5A5) $display("FAIL same7_data: got %0h want a5a5a5a5", rd_data[0 +: DATA_W]); else nPass++;
    nChecks++; if (rd_busy[0] !== 1'b1) $display("FAIL same7_busy: got %b want 1", rd_busy[0]); else nPass++;
    nChecks++; if (busy_cnt !== 6'd1) $display("FAIL same7_cnt: got %0d want 1", busy_cnt); else nPass++;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7;
    tick();
    idle();
    #1;
    nChecks++; if (busy_cnt !== 6'd0) $display("FAIL same7_clear_cnt: got %0d want 0", busy_cnt); else nPass++;
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] want;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234;
    rd_addr[ADDR_W +: ADDR_W] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'h1111;
`endif
    nChecks++; if (rd_data[DATA_W +: DATA_W] !== want) $display("FAIL byp9_same: got %0h want %0h", rd_data[DATA_W +: DATA_W], want); else nPass++;
    tick();
    idle();
    #1;
    nChecks++; if (rd_data[DATA_W +: DATA_W] !== 32'h1234) $display("FAIL byp9_next: got %0h want 1234", rd_data[DATA_W +: DATA_W]); else nPass++;
  endtask

  task automatic test_fill_reset();
    for (int a = 1; a < DEPTH; a++) begin
      rsv_en = 1'b1; rsv_addr = ADDR_W'(a);
      tick();
    end
    rsv_addr = 5'd12;
    #1;
    nChecks++; if (rsv_ok !== 1'b0) $display("FAIL fill_rsv12: got %b want 0", rsv_ok); else nPass++;
    nChecks++; if (busy_cnt !== 6'd31) $display("FAIL fill_cnt: got %0d want 31", busy_cnt); else nPass++;
    idle();
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    nChecks++; if (busy_cnt !== 6'd0) $display("FAIL fill_rst_cnt: got %0d want 0", busy_cnt); else nPass++;
    rst_n = 1'b1;
    tick();
    rd_addr[0 +: ADDR_W] = 5'd12;
    rd_addr[ADDR_W +: ADDR_W] = 5'd31;
    #1;
    nChecks++; if (rd_busy !== 2'b00) $display("FAIL fill_rst_busy: got %b want 00", rd_busy); else nPass++;
    nChecks++; if (busy_cnt !== 6'd0) $display("FAIL fill_rst_cnt2: got %0d want 0", busy_cnt); else nPass++;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int c = 0; c < 300; c++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = rndAddr();
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = rndAddr();
      for (int p = 0; p < NUM_RD; p++) rd_addr[p*ADDR_W +: ADDR_W] = rndAddr();
      #1;
      nChecks++; if (rsv_ok !== expRsvOk()) $display("FAIL rnd_rsv_ok c=%0d: got %b want %b", c, rsv_ok, expRsvOk()); else nPass++;
      nChecks++; if (busy_cnt !== 6'(mCnt)) $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, busy_cnt, mCnt); else nPass++;
      for (int p = 0; p < NUM_RD; p++) begin
        a = rd_addr[p*ADDR_W +: ADDR_W];
        nChecks++; if (rd_data[p*DATA_W +: DATA_W] !== expRd(a)) $display("FAIL rnd_rd c=%0d p=%0d: got %0h want %0h", c, p, rd_data[p*DATA_W +: DATA_W], expRd(a)); else nPass++;
        nChecks++; if (rd_busy[p] !== expBusy(a)) $display("FAIL rnd_busy c=%0d p=%0d: got %b want %b", c, p, rd_busy[p], expBusy(a)); else nPass++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst_n   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en  = 1'b0; rsv_addr = '0;
    modelReset();
    test_reset();
    test_write_read();
    test_reserve();
    test_write_rsv_same();
    test_bypass();
    test_fill_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, legal range 1..4.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port rd_addr  input  NUM_RD*ADDR_W: packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
REQ-007 Port rd_data  output  NUM_RD*DATA_W: packed read data, same packing as rd_addr.
REQ-008 Port rd_busy  output  NUM_RD: busy flag of the register addressed by each read port.
REQ-009 Port wr_en  input  1: write strobe.
REQ-010 Port wr_addr  input  ADDR_W: write address.
REQ-011 Port wr_data  input  DATA_W: write data.
REQ-012 Port rsv_en  input  1: reservation request, marks a destination register pending.
REQ-013 Port rsv_addr  input  ADDR_W: register to reserve.
REQ-014 Port rsv_ok  output  1: reservation accepted this cycle (combinational).
REQ-015 Port busy_cnt  output  ADDR_W+1: number of registers currently busy (registered).

Function
REQ-016 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], with no clock latency.
REQ-017 Register 0 SHALL always read 0 and never be busy; writes and reservations to address 0 have no effect on state.
REQ-018 A write with wr_en=1 and wr_addr!=0 SHALL update reg[wr_addr] on the rising edge; the new value is visible on the read ports from the following cycle.
REQ-019 A write SHALL clear busy[wr_addr] on the same edge, unless an accepted reservation targets the same address in that cycle.
REQ-020 rsv_ok SHALL be 1 iff rsv_en=1 and one of the following holds: rsv_addr=0; busy[rsv_addr]=0; or wr_en=1 with wr_addr=rsv_addr.
REQ-021 An accepted reservation with rsv_addr!=0 SHALL set busy[rsv_addr] on the edge; reservation wins over a simultaneous write-clear of the same address.
REQ-022 A rejected reservation (rsv_en=1, rsv_ok=0) SHALL leave all state unchanged; the requester holds and retries.
REQ-023 rd_busy[i] SHALL equal busy[rd_addr[i]] (current registered state).
REQ-024 busy_cnt SHALL track the population of busy[]: +1 on set only, -1 on clear only, unchanged when set and clear coincide or cancel; it never exceeds 2**ADDR_W-1.
REQ-025 A write to a non-busy register SHALL be legal and SHALL update data only.

Reset
REQ-026 rst_n low SHALL immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-027 While rst_n is low: rd_data reads 0, rd_busy=0 and rsv_ok follows REQ-020 using cleared state; no write or reservation takes effect.
REQ-028 Reset asserted mid-cycle SHALL discard any in-flight write or reservation for that edge.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when wr_en=1 and wr_addr=rd_addr[i]!=0, rd_data[i] SHALL return wr_data in the same cycle and rd_busy[i] SHALL read 0.
REQ-030 Without REGFILE_BYPASS_EN: no forwarding; reads return stored contents per REQ-016/REQ-023 only.

Structure
REQ-031 Package regfile_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and the packed-port slice helper.
REQ-032 Sub-module regfile_rd_port (one read mux plus bypass and busy lookup) SHALL be instantiated NUM_RD times via generate.

Verification
REQ-033 Reset: hold rst_n=0 after random writes -> all rd_data=0, rd_busy=0, busy_cnt=0.
REQ-034 Write reg 3 = 0x0000F0F0, then read port 0 at addr 3 the next cycle -> 0x0000F0F0; write reg 0 = 0xFFFFFFFF -> reads 0.
REQ-035 Reserve reg 5 -> rsv_ok=1, next cycle rd_busy=1 and busy_cnt=1; re-reserve reg 5 -> rsv_ok=0; write reg 5 -> busy clears and busy_cnt=0.
REQ-036 Same cycle: write reg 7 (busy) and reserve reg 7 -> rsv_ok=1, reg 7 updated, busy stays 1, busy_cnt unchanged.
REQ-037 With REGFILE_BYPASS_EN: wr_en=1, wr_addr=9, wr_data=0x1234, rd_addr[1]=9 -> rd_data[1]=0x1234 in the same cycle; without the macro -> old value.
REQ-038 Reserve all 31 non-zero registers -> busy_cnt=31; pulse rst_n low between edges -> busy_cnt=0 immediately.
